imm_ext_ctrl: RTL

IMM_EXT_CTRL -- requirements
Module: imm_ext_ctrl

---
 rtl/imm_ext_ctrl_pkg.sv | 55 +++++
 rtl/imm_ext_ctrl_extender.sv | 25 ++
 rtl/imm_ext_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/imm_ext_ctrl_pkg.sv
// Shared definitions for the immediate-extension controller:
//   - ext_mode_e : extension mode encoding driven on the ext_mode port
//   - state_e    : controller FSM state encoding
//   - OP_*       : supported opcodes (instr[31:26])
//   - decode_opcode() : opcode -> {mode, illegal} lookup
package imm_ext_ctrl_pkg;

    typedef enum logic [1:0] {
        EXT_SIGN   = 2'd0,
        EXT_ZERO   = 2'd1,
        EXT_UPPER  = 2'd2,
        EXT_BRANCH = 2'd3
    } ext_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXTEND = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        ext_mode_e mode;
        logic      illegal;
    } decode_t;

    // Unsupported opcodes report illegal with the SIGN mode as a harmless default.
    function automatic decode_t decode_opcode(input logic [5:0] opcode);
        decode_t d;
        d.mode    = EXT_SIGN;
        d.illegal = 1'b0;
        case (opcode)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: d.mode = EXT_SIGN;
            OP_ANDI, OP_ORI, OP_XORI:                           d.mode = EXT_ZERO;
            OP_LUI:                                             d.mode = EXT_UPPER;
            OP_BEQ, OP_BNE:                                     d.mode = EXT_BRANCH;
            default:                                            d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_ext_ctrl_extender.sv
// imm_extender: purely combinational 16 -> 32 bit immediate extension.
// Ports:
//   imm_16   in  16-bit raw immediate
//   ext_mode in  extension mode (SIGN/ZERO/UPPER/BRANCH)
//   imm_32   out extended immediate
module imm_extender
    import imm_ext_ctrl_pkg::*;
(
    input  logic [15:0] imm_16,
    input  ext_mode_e   ext_mode,
    output logic [31:0] imm_32
);

    always_comb begin
        // NOTE: assign a default before the case so no path leaves imm_32 unassigned (no latch).
        imm_32 = {{16{imm_16[15]}}, imm_16};
        unique case (ext_mode)
            EXT_SIGN:   imm_32 = {{16{imm_16[15]}}, imm_16};
            EXT_ZERO:   imm_32 = {16'b0, imm_16};
            EXT_UPPER:  imm_32 = {imm_16, 16'b0};
            EXT_BRANCH: imm_32 = {{14{imm_16[15]}}, imm_16, 2'b00};
        endcase
    end

endmodule

// File: rtl/imm_ext_ctrl.sv
// imm_ext_ctrl: accepts one instruction word at a time, decodes its opcode
// into an extension mode, extends the 16-bit immediate and presents the result
// until the consumer takes it. One instruction in flight; IDLE->DECODE->EXTEND->HOLD.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   instruction handshake (in_ready only in IDLE)
//   instr               instruction word, [31:26] opcode, [15:0] immediate
//   out_valid/out_ready result handshake (out_valid only in HOLD)
//   imm_32, ext_mode, illegal  registered result
//   ext_count           wrapping count of completed result handshakes
module imm_ext_ctrl
    import imm_ext_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      imm_32,
    output logic [1:0]       ext_mode,
    output logic             illegal,
    output logic [CNT_W-1:0] ext_count
);

    state_e      state;
    logic [5:0]  opcode_q;
    logic [15:0] imm_16_q;
    ext_mode_e   mode_q;
    decode_t     dec;
    logic [31:0] ext_value;

    assign dec      = decode_opcode(opcode_q);
    assign ext_mode = mode_q;

    imm_extender u_imm_extender (
        .imm_16   (imm_16_q),
        .ext_mode (mode_q),
        .imm_32   (ext_value)
    );

    // Handshake flags are registered alongside the state so they are glitch-free
    // and always agree with it: in_ready <=> IDLE, out_valid <=> HOLD.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= ST_IDLE;
            opcode_q  <= '0;
            imm_16_q  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            imm_32    <= '0;
            mode_q    <= EXT_SIGN;
            illegal   <= 1'b0;
            ext_count <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        opcode_q <= instr[31:26];
                        imm_16_q <= instr[15:0];
                        in_ready <= 1'b0;
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    mode_q  <= dec.mode;
                    illegal <= dec.illegal;
                    state   <= ST_EXTEND;
                end
                ST_EXTEND: begin
                    imm_32    <= illegal ? 32'h0 : ext_value;
                    out_valid <= 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        ext_count <= ext_count + CNT_W'(1);
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
